bcd_digit_collector: RTL
========================

BCD_DIGIT_COLLECTOR -- requirements
Module: bcd_digit_collector

Interface
REQ-001 The block SHALL take parameter NDIG, default 4, as the number of BCD digits held in Value (legal range 1..8).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Z, input, 1 bit: serial BCD bit stream from the Excess-3 converter, LSB first, one bit per clock, 4 bits per digit, frame-aligned to reset release.
REQ-005 The block SHALL have port Clr, input, 1 bit: synchronous clear of Value and Count.
REQ-006 The block SHALL have port Digit, output, 4 bits: last completed nibble, valid or not.
REQ-007 The block SHALL have port Valid, output, 1 bit: one-cycle pulse, legal digit (0..9) completed.
REQ-008 The block SHALL have port Err, output, 1 bit: one-cycle pulse, illegal nibble (10..15) completed.
REQ-009 The block SHALL have port Value, output, 4*NDIG bits: digit history; newest digit in bits [3:0], older digits shifted toward the MSB.
REQ-010 The block SHALL have port Count, output, 4 bits: number of legal digits in Value, saturating at NDIG.

Function
REQ-011 The block SHALL sample Z on every rising Clk edge while Rst is high; it SHALL have no enable and no stall.
REQ-012 A 2-bit bit-position FSM SHALL step B0->B1->B2->B3->B0, one state per edge, and wrap unconditionally after B3.
REQ-013 The block SHALL store Z sampled in state Bk as bit k of a 4-bit partial register.
REQ-014 On the B3 edge, the block SHALL form nibble = {Z, partial[2:0]} and load it into Digit.
REQ-015 Digit, Valid and Err SHALL all be registered, so they are visible in the cycle after the B3 edge (latency 1 cycle from the last bit's capture).
REQ-016 If nibble <= 9, the B3 edge SHALL set Valid=1, set Err=0, shift Value left by 4 with the nibble entering bits [3:0], and increment Count, saturating at NDIG.
REQ-017 If nibble >= 10, the B3 edge SHALL set Err=1, set Valid=0, and leave Value and Count unchanged.
REQ-018 On any edge other than B3, Valid and Err SHALL be 0; Valid and Err SHALL never both be 1.
REQ-019 When Value is full (Count=NDIG), a new legal digit SHALL discard the oldest digit (the top nibble); Count SHALL stay at NDIG.
REQ-020 Clr=1 on a non-B3 edge SHALL clear Value and Count to 0 and SHALL NOT disturb the FSM, the partial register or Digit.
REQ-021 Clr=1 on a B3 edge with a legal nibble SHALL set Value={0...,nibble}, Count=1 and Valid=1.
REQ-022 Clr=1 on a B3 edge with an illegal nibble SHALL set Value=0, Count=0 and Err=1.
REQ-023 Digit SHALL hold its value between completions.

Reset
REQ-024 Rst low SHALL immediately, without waiting for a clock, force FSM=B0, partial=0, Digit=0, Valid=0, Err=0, Value=0 and Count=0.
REQ-025 Rst asserted mid-digit SHALL discard the partial nibble with no Valid/Err pulse; the first edge after release SHALL capture bit 0 of a new digit.
REQ-026 A reset pulse shorter than one clock period SHALL still take full effect.

Verification
REQ-027 Reset release, Z=1,0,0,1 on four edges -> next cycle Digit=4'h9, Valid=1 for exactly one cycle, Value=16'h0009, Count=1.
REQ-028 Digits 1,2,3,4,5 sent back-to-back (20 edges) -> Value=16'h2345, Count=4 after the 4th and 5th digits, five Valid pulses spaced exactly 4 cycles apart.
REQ-029 Digit 3, then Z=0,1,0,1 (nibble 4'hA) -> Err=1 for one cycle, Digit=4'hA, Value=16'h0003, Count=1, Valid=0 on that completion.
REQ-030 Two bits of a digit, then Rst low for 3 ns between edges, then release and Z=0,1,1,0 -> no pulse from the aborted digit, then Valid with Digit=4'h6, Value=16'h0006, Count=1.
REQ-031 Value=16'h0078, Count=2, Clr=1 on the B3 edge of digit 5 -> Value=16'h0005, Count=1, Valid=1; Clr=1 on a B1 edge instead -> Value=0, Count=0, then the digit completes normally giving Value=16'h0005, Count=1.
REQ-032 Random stimulus from the Excess-3 converter, 10000 digits with random reset -> a reference model agrees on Digit, Valid, Err, Value and Count every cycle.

Source files
------------

// File: rtl/bcd_digit_collector.sv
// Collects a serial LSB-first BCD bit stream into nibbles, flags legal/illegal
// digits and keeps a shifting history of the last NDIG legal digits.
module bcd_digit_collector #(
    parameter int NDIG = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Z,
    input  logic              Clr,
    output logic [3:0]        Digit,
    output logic              Valid,
    output logic              Err,
    output logic [4*NDIG-1:0] Value,
    output logic [3:0]        Count,
    output logic [1:0]        State
);

    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} bitpos_t;

    localparam logic [3:0] NDIG_C = 4'(NDIG);

    bitpos_t            state;
    logic [2:0]         partial;
    logic [3:0]         nibble;
    logic               legal;
    logic [4*NDIG+3:0]  shifted;
    logic [3:0]         count_inc;

    always_comb begin
        nibble    = {Z, partial};
        legal     = (nibble <= 4'd9);
        shifted   = {Value, nibble};
        count_inc = (Count == NDIG_C) ? Count : Count + 4'd1;
    end

    assign State = state;

    // Valid and Err are single-cycle pulses with no ready: the consumer must
    // take the digit in the cycle it is flagged, the stream never stalls.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= B0;
            partial <= 3'd0;
            Digit   <= 4'd0;
            Valid   <= 1'b0;
            Err     <= 1'b0;
            Value   <= '0;
            Count   <= 4'd0;
        end else begin
            Valid <= 1'b0;
            Err   <= 1'b0;
            case (state)
                B0: begin
                    partial[0] <= Z;
                    state      <= B1;
                end
                B1: begin
                    partial[1] <= Z;
                    state      <= B2;
                end
                B2: begin
                    partial[2] <= Z;
                    state      <= B3;
                end
                default: begin
                    state <= B0;
                    Digit <= nibble;
                end
            endcase

            if (state == B3) begin
                if (legal) begin
                    Valid <= 1'b1;
                    // A clear coinciding with a legal completion keeps only the new digit
                    if (Clr) begin
                        Value <= {{(4*NDIG-4){1'b0}}, nibble};
                        Count <= 4'd1;
                    end else begin
                        Value <= shifted[4*NDIG-1:0];
                        Count <= count_inc;
                    end
                end else begin
                    Err <= 1'b1;
                    if (Clr) begin
                        Value <= '0;
                        Count <= 4'd0;
                    end
                end
            end else if (Clr) begin
                Value <= '0;
                Count <= 4'd0;
            end
        end
    end

endmodule
